// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and defaults for the hazard scoreboard.
// Define HAZARD_LONG_FWD_EN to forward long-unit results from the writeback bus.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10,
        FWD_LONG = 2'b11
    } fwd_sel_t;

    localparam int DEFAULT_MAX_OUT = 2;

`ifdef HAZARD_LONG_FWD_EN
    localparam bit LONG_FWD_EN = 1'b1;
`else
    localparam bit LONG_FWD_EN = 1'b0;
`endif

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard unit signal bundle; master is the pipeline, slave the hazard unit.
interface hazard_scoreboard_if #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) ();
    import hazard_pkg::*;

    logic [AW-1:0]   Rs1D, Rs2D, RdD;
    logic            RegWriteD;
    logic [AW-1:0]   Rs1E, Rs2E, RdE;
    logic            ResultSrcEb0, PCSrcE;
    logic [AW-1:0]   RdM, RdW;
    logic            RegWriteM, RegWriteW;
    logic            LongIssueE, LongBusy, LongDone;
    logic [AW-1:0]   LongRd;
    fwd_sel_t        ForwardAE, ForwardBE;
    logic            StallF, StallD, StallE;
    logic            FlushD, FlushE, FlushM;
    logic [NREG-1:0] Pending;
    logic [2:0]      OutCnt;

    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, Rs1E, Rs2E, RdE, ResultSrcEb0, PCSrcE,
               RdM, RdW, RegWriteM, RegWriteW, LongIssueE, LongBusy, LongDone, LongRd,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
               Pending, OutCnt
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, Rs1E, Rs2E, RdE, ResultSrcEb0, PCSrcE,
               RdM, RdW, RegWriteM, RegWriteW, LongIssueE, LongBusy, LongDone, LongRd,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
               Pending, OutCnt
    );
endinterface

// File: rtl/hazard_scoreboard_fwd_sel.sv
// Operand bypass select for one execute-stage source; M beats W beats the long-unit bus.
// The long-unit leg is only live when HAZARD_LONG_FWD_EN is defined.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rsE,
    input  logic [AW-1:0] rdM,
    input  logic          regWriteM,
    input  logic [AW-1:0] rdW,
    input  logic          regWriteW,
    input  logic          longDone,
    input  logic [AW-1:0] longRd,
    output fwd_sel_t      fwdSel
);

    logic rsNz;
    assign rsNz = (rsE != '0);

    always_comb begin
        fwdSel = FWD_RF;
        if (rsNz && regWriteM && (rdM == rsE)) begin
            fwdSel = FWD_M;
        end else if (rsNz && regWriteW && (rdW == rsE)) begin
            fwdSel = FWD_W;
        end else if (LONG_FWD_EN && rsNz && longDone && (longRd == rsE)) begin
            fwdSel = FWD_LONG;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: bypass selects, load-use / scoreboard / structural stalls and long-op tracking.
// HAZARD_LONG_FWD_EN lets a retiring long op release dependent stalls in the same cycle.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int AW      = $clog2(NREG),
    parameter int MAX_OUT = DEFAULT_MAX_OUT
) (
    input logic           clk,
    input logic           reset,
    hazard_scoreboard_if.slave hz
);

    logic [NREG-1:0] pendingQ, pendingEff, setMask, clrMask;
    logic [2:0]      outCntQ;
    logic            lwStall, sbStall, stStall, bubble;
    logic            cntFull, accept, retire;

    hazard_fwd_sel #(.AW(AW)) u_fwdA (
        .rsE(hz.Rs1E), .rdM(hz.RdM), .regWriteM(hz.RegWriteM), .rdW(hz.RdW),
        .regWriteW(hz.RegWriteW), .longDone(hz.LongDone), .longRd(hz.LongRd),
        .fwdSel(hz.ForwardAE)
    );

    hazard_fwd_sel #(.AW(AW)) u_fwdB (
        .rsE(hz.Rs2E), .rdM(hz.RdM), .regWriteM(hz.RegWriteM), .rdW(hz.RdW),
        .regWriteW(hz.RegWriteW), .longDone(hz.LongDone), .longRd(hz.LongRd),
        .fwdSel(hz.ForwardBE)
    );

    assign clrMask = hz.LongDone ? (NREG'(1) << hz.LongRd) : '0;
    assign setMask = (accept && (hz.RdE != '0)) ? (NREG'(1) << hz.RdE) : '0;

    // While reset is held the stall logic already sees the cleared scoreboard.
    always_comb begin
        pendingEff = reset ? '0 : pendingQ;
        if (LONG_FWD_EN) begin
            pendingEff = pendingEff & ~clrMask;
        end
    end

    assign lwStall = hz.ResultSrcEb0 && (hz.RdE != '0) &&
                     ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
    assign sbStall = ((hz.Rs1D != '0) && pendingEff[hz.Rs1D]) ||
                     ((hz.Rs2D != '0) && pendingEff[hz.Rs2D]) ||
                     (hz.RegWriteD && pendingEff[hz.RdD]);
    assign cntFull = !reset && (outCntQ == 3'(MAX_OUT));
    assign stStall = hz.LongIssueE && (hz.LongBusy || cntFull);
    assign bubble  = lwStall || sbStall;
    assign accept  = hz.LongIssueE && !stStall;
    assign retire  = hz.LongDone && (outCntQ != 3'd0);

    assign hz.StallF  = stStall || (!hz.PCSrcE && bubble);
    assign hz.StallD  = stStall || (!hz.PCSrcE && bubble);
    assign hz.StallE  = stStall;
    assign hz.FlushD  = hz.PCSrcE;
    assign hz.FlushE  = !stStall && (hz.PCSrcE || bubble);
    assign hz.FlushM  = stStall;
    assign hz.Pending = pendingQ;
    assign hz.OutCnt  = outCntQ;

    // Set wins over clear so a reissue to the retiring register stays tracked.
    always_ff @(posedge clk) begin
        if (reset) begin
            pendingQ <= '0;
            outCntQ  <= 3'd0;
        end else begin
            pendingQ <= (pendingQ & ~clrMask) | setMask;
            case ({accept, retire})
                2'b10:   outCntQ <= outCntQ + 3'd1;
                2'b01:   outCntQ <= outCntQ - 3'd1;
                default: outCntQ <= outCntQ;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard-style bench for hazard_scoreboard; expectations come from a small reference model
// plus fixed per-step values for the headline behaviours.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NREG = 32;
    localparam int AW   = 5;
`ifdef HAZARD_LONG_FWD_EN
    localparam bit LFWD = 1'b1;
`else
    localparam bit LFWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NREG(NREG), .AW(AW)) hif ();

    hazard_scoreboard #(.NREG(NREG), .AW(AW), .MAX_OUT(2)) dut (
        .clk(clk),
        .reset(reset),
        .hz(hif)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        string           tag;
        logic [12:0]     vec;
        logic [NREG-1:0] pend;
    } exp_t;
    exp_t q[$];

    logic [12:0] obsVec;
    assign obsVec = {hif.ForwardAE, hif.ForwardBE, hif.StallF, hif.StallD, hif.StallE,
                     hif.FlushD, hif.FlushE, hif.FlushM, hif.OutCnt};

    // Reference model state
    logic [NREG-1:0] mPend, mPendNext;
    logic [2:0]      mCnt, mCntNext;
    logic            mSt, mAcc, mDec;

    always_comb begin
        mSt = hif.LongIssueE && (hif.LongBusy || (mCnt == 3'd2));
        mAcc = hif.LongIssueE && !mSt;
        mDec = hif.LongDone && (mCnt != 3'd0);
        mPendNext = mPend;
        if (hif.LongDone) mPendNext[hif.LongRd] = 1'b0;
        if (mAcc && (hif.RdE != '0)) mPendNext[hif.RdE] = 1'b1;
        mCntNext = mCnt + 3'(mAcc) - 3'(mDec);
    end

    always @(posedge clk) begin
        if (reset) begin
            mPend <= '0;
            mCnt  <= 3'd0;
        end else begin
            mPend <= mPendNext;
            mCnt  <= mCntNext;
        end
    end

    function automatic logic [1:0] mFwd(logic [AW-1:0] rs);
        if (rs != '0 && hif.RegWriteM && hif.RdM == rs) return 2'b10;
        if (rs != '0 && hif.RegWriteW && hif.RdW == rs) return 2'b01;
        if (LFWD && rs != '0 && hif.LongDone && hif.LongRd == rs) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [12:0] modelVec();
        logic [NREG-1:0] pe;
        logic lw, sb, st, bub;
        pe = reset ? '0 : mPend;
        if (LFWD && hif.LongDone) pe[hif.LongRd] = 1'b0;
        lw = hif.ResultSrcEb0 && hif.RdE != '0 && (hif.Rs1D == hif.RdE || hif.Rs2D == hif.RdE);
        sb = (hif.Rs1D != '0 && pe[hif.Rs1D]) || (hif.Rs2D != '0 && pe[hif.Rs2D]) ||
             (hif.RegWriteD && pe[hif.RdD]);
        st = hif.LongIssueE && (hif.LongBusy || (!reset && mCnt == 3'd2));
        bub = lw || sb;
        return {mFwd(hif.Rs1E), mFwd(hif.Rs2E), st || (!hif.PCSrcE && bub),
                st || (!hif.PCSrcE && bub), st, hif.PCSrcE,
                !st && (hif.PCSrcE || bub), st, mCnt};
    endfunction

    task automatic idle();
        reset = 1'b0;
        hif.Rs1D = '0; hif.Rs2D = '0; hif.RdD = '0; hif.RegWriteD = 1'b0;
        hif.Rs1E = '0; hif.Rs2E = '0; hif.RdE = '0;
        hif.ResultSrcEb0 = 1'b0; hif.PCSrcE = 1'b0;
        hif.RdM = '0; hif.RdW = '0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
        hif.LongIssueE = 1'b0; hif.LongBusy = 1'b0; hif.LongDone = 1'b0; hif.LongRd = '0;
    endtask

    task automatic pushExp(string tag);
        exp_t e;
        e.tag = tag;
        e.vec = modelVec();
        e.pend = mPend;
        q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle();
            reset = 1'b1;
            hif.LongIssueE = 1'b1; hif.RdE = 5'd4;
            hif.LongDone = 1'b1; hif.LongRd = 5'd4;
            pushExp("reset");
            #1;
            e = q.pop_front();
            checks++;
            if (obsVec !== e.vec) begin
                failures++;
                $display("FAIL %s[%0d] outputs got=%b exp=%b", e.tag, i, obsVec, e.vec);
            end
            checks++;
            if (hif.Pending !== '0 || hif.OutCnt !== 3'd0 || hif.StallE !== 1'b0) begin
                failures++;
                $display("FAIL reset_state[%0d] Pending=%h OutCnt=%0d StallE=%b exp 0/0/0",
                         i, hif.Pending, hif.OutCnt, hif.StallE);
            end
        end
    endtask

    task automatic test_forwarding();
        exp_t e;
        logic [AW-1:0] t1 [5] = '{5'd5, 5'd0, 5'd7, 5'd3, 5'd3};
        logic [AW-1:0] t2 [5] = '{5'd6, 5'd0, 5'd8, 5'd3, 5'd4};
        logic [AW-1:0] tm [5] = '{5'd5, 5'd0, 5'd8, 5'd3, 5'd3};
        logic          twm[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [AW-1:0] tw [5] = '{5'd5, 5'd0, 5'd7, 5'd3, 5'd4};
        logic          tww[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0]    xa [5] = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
        logic [1:0]    xb [5] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idle();
            hif.Rs1E = t1[i]; hif.Rs2E = t2[i];
            hif.RdM = tm[i]; hif.RegWriteM = twm[i];
            hif.RdW = tw[i]; hif.RegWriteW = tww[i];
            pushExp("fwd");
            #1;
            e = q.pop_front();
            checks++;
            if (obsVec !== e.vec) begin
                failures++;
                $display("FAIL %s[%0d] outputs got=%b exp=%b", e.tag, i, obsVec, e.vec);
            end
            checks++;
            if (hif.ForwardAE !== xa[i] || hif.ForwardBE !== xb[i]) begin
                failures++;
                $display("FAIL fwd_sel[%0d] A=%b B=%b exp A=%b B=%b",
                         i, hif.ForwardAE, hif.ForwardBE, xa[i], xb[i]);
            end
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        logic xs[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle();
            case (i)
                0: begin hif.ResultSrcEb0 = 1'b1; hif.RdE = 5'd7; hif.Rs2D = 5'd7; end
                1: begin hif.RdE = 5'd7; hif.Rs2D = 5'd7; end
                2: begin hif.ResultSrcEb0 = 1'b1; hif.RdE = 5'd0; end
                default: begin hif.ResultSrcEb0 = 1'b1; hif.RdE = 5'd7; hif.Rs1D = 5'd6; end
            endcase
            pushExp("loaduse");
            #1;
            e = q.pop_front();
            checks++;
            if (obsVec !== e.vec) begin
                failures++;
                $display("FAIL %s[%0d] outputs got=%b exp=%b", e.tag, i, obsVec, e.vec);
            end
            checks++;
            if ({hif.StallF, hif.StallD, hif.FlushE, hif.StallE} !== {xs[i], xs[i], xs[i], 1'b0}) begin
                failures++;
                $display("FAIL loaduse_ctl[%0d] F/D/FlE/E=%b%b%b%b exp=%b%b%b0", i,
                         hif.StallF, hif.StallD, hif.FlushE, hif.StallE, xs[i], xs[i], xs[i]);
            end
        end
    endtask

    task automatic test_scoreboard();
        exp_t e;
        logic       xs[5] = '{1'b0, 1'b1, 1'b1, !LFWD, 1'b0};
        logic       xp[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] xc[5] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idle();
            case (i)
                0: begin hif.LongIssueE = 1'b1; hif.RdE = 5'd9; end
                1: hif.Rs1D = 5'd9;
                2: begin hif.RdD = 5'd9; hif.RegWriteD = 1'b1; end
                3: begin hif.Rs1D = 5'd9; hif.LongDone = 1'b1; hif.LongRd = 5'd9; end
                default: hif.Rs1D = 5'd9;
            endcase
            pushExp("sb");
            #1;
            e = q.pop_front();
            checks++;
            if (obsVec !== e.vec || hif.Pending !== e.pend) begin
                failures++;
                $display("FAIL %s[%0d] got=%b/%h exp=%b/%h", e.tag, i, obsVec, hif.Pending, e.vec, e.pend);
            end
            checks++;
            if (hif.StallF !== xs[i] || hif.Pending[9] !== xp[i] || hif.OutCnt !== xc[i]) begin
                failures++;
                $display("FAIL sb_seq[%0d] StallF=%b P9=%b OutCnt=%0d exp %b %b %0d",
                         i, hif.StallF, hif.Pending[9], hif.OutCnt, xs[i], xp[i], xc[i]);
            end
        end
    endtask

    task automatic test_structural();
        exp_t e;
        logic       xs[13] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        logic [2:0] xc[13] = '{0, 1, 2, 2, 1, 2, 1, 1, 1, 1, 0, 0, 0};
        for (int i = 0; i < 13; i++) begin
            @(negedge clk); idle();
            case (i)
                0: begin hif.LongIssueE = 1'b1; hif.RdE = 5'd10; end
                1: begin hif.LongIssueE = 1'b1; hif.RdE = 5'd11; end
                2: begin hif.LongIssueE = 1'b1; hif.RdE = 5'd12; end
                3: begin hif.LongIssueE = 1'b1; hif.RdE = 5'd12; hif.LongDone = 1'b1; hif.LongRd = 5'd10; end
                4: begin hif.LongIssueE = 1'b1; hif.RdE = 5'd12; end
                5: begin hif.LongDone = 1'b1; hif.LongRd = 5'd11; end
                6: begin hif.LongIssueE = 1'b1; hif.RdE = 5'd13; hif.LongDone = 1'b1; hif.LongRd = 5'd12; end
                7: begin hif.LongIssueE = 1'b1; hif.RdE = 5'd13; hif.LongDone = 1'b1; hif.LongRd = 5'd13; end
                8: ;
                9, 10: begin hif.LongDone = 1'b1; hif.LongRd = 5'd13; end
                11: begin hif.LongIssueE = 1'b1; hif.RdE = 5'd14; hif.LongBusy = 1'b1; end
                default: ;
            endcase
            pushExp("struct");
            #1;
            e = q.pop_front();
            checks++;
            if (obsVec !== e.vec || hif.Pending !== e.pend) begin
                failures++;
                $display("FAIL %s[%0d] got=%b/%h exp=%b/%h", e.tag, i, obsVec, hif.Pending, e.vec, e.pend);
            end
            checks++;
            if ({hif.StallF, hif.StallE, hif.FlushM, hif.FlushE} !== {xs[i], xs[i], xs[i], 1'b0} ||
                hif.OutCnt !== xc[i]) begin
                failures++;
                $display("FAIL struct_ctl[%0d] F/E/FlM/FlE=%b%b%b%b OutCnt=%0d exp %b%b%b0 %0d", i,
                         hif.StallF, hif.StallE, hif.FlushM, hif.FlushE, hif.OutCnt,
                         xs[i], xs[i], xs[i], xc[i]);
            end
        end
        checks++;
        if (hif.Pending[13] !== 1'b0 || hif.Pending[14] !== 1'b0) begin
            failures++;
            $display("FAIL struct_final P13=%b P14=%b exp 0 0", hif.Pending[13], hif.Pending[14]);
        end
    endtask

    task automatic test_branch();
        exp_t e;
        logic xf[2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle();
            hif.PCSrcE = (i == 0);
            hif.ResultSrcEb0 = 1'b1; hif.RdE = 5'd7; hif.Rs1D = 5'd7;
            pushExp("branch");
            #1;
            e = q.pop_front();
            checks++;
            if (obsVec !== e.vec) begin
                failures++;
                $display("FAIL %s[%0d] outputs got=%b exp=%b", e.tag, i, obsVec, e.vec);
            end
            checks++;
            if ({hif.StallF, hif.StallD, hif.FlushD, hif.FlushE} !== {xf[i], xf[i], !xf[i], 1'b1}) begin
                failures++;
                $display("FAIL branch_ctl[%0d] F/D/FlD/FlE=%b%b%b%b exp=%b%b%b1", i,
                         hif.StallF, hif.StallD, hif.FlushD, hif.FlushE, xf[i], xf[i], !xf[i]);
            end
        end
    endtask

    task automatic test_long_fwd();
        exp_t e;
        logic [1:0] xb[2] = '{LFWD ? 2'b11 : 2'b00, 2'b01};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle();
            hif.LongDone = 1'b1; hif.LongRd = 5'd6; hif.Rs2E = 5'd6;
            if (i == 1) begin hif.RdW = 5'd6; hif.RegWriteW = 1'b1; end
            pushExp("longfwd");
            #1;
            e = q.pop_front();
            checks++;
            if (obsVec !== e.vec) begin
                failures++;
                $display("FAIL %s[%0d] outputs got=%b exp=%b", e.tag, i, obsVec, e.vec);
            end
            checks++;
            if (hif.ForwardBE !== xb[i] || hif.OutCnt !== 3'd0) begin
                failures++;
                $display("FAIL longfwd_sel[%0d] B=%b OutCnt=%0d exp %b 0", i, hif.ForwardBE, hif.OutCnt, xb[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [NREG-1:0] xp[3] = '{32'h0, 32'h8, 32'h0};
        logic [2:0]      xc[3] = '{3'd0, 3'd1, 3'd0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle();
            case (i)
                0: begin hif.LongIssueE = 1'b1; hif.RdE = 5'd3; end
                1: begin reset = 1'b1; hif.LongIssueE = 1'b1; hif.RdE = 5'd4; end
                default: ;
            endcase
            pushExp("rstmid");
            #1;
            e = q.pop_front();
            checks++;
            if (obsVec !== e.vec || hif.Pending !== e.pend) begin
                failures++;
                $display("FAIL %s[%0d] got=%b/%h exp=%b/%h", e.tag, i, obsVec, hif.Pending, e.vec, e.pend);
            end
            checks++;
            if (hif.Pending !== xp[i] || hif.OutCnt !== xc[i] || hif.StallF !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_state[%0d] Pending=%h OutCnt=%0d StallF=%b exp %h %0d 0",
                         i, hif.Pending, hif.OutCnt, hif.StallF, xp[i], xc[i]);
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); idle();
            reset = ($urandom_range(0, 49) == 0);
            hif.Rs1D = AW'($urandom_range(0, 7)); hif.Rs2D = AW'($urandom_range(0, 7));
            hif.RdD = AW'($urandom_range(0, 7)); hif.RegWriteD = 1'($urandom_range(0, 1));
            hif.Rs1E = AW'($urandom_range(0, 7)); hif.Rs2E = AW'($urandom_range(0, 7));
            hif.RdE = AW'($urandom_range(0, 7)); hif.ResultSrcEb0 = 1'($urandom_range(0, 1));
            hif.RdM = AW'($urandom_range(0, 7)); hif.RegWriteM = 1'($urandom_range(0, 1));
            hif.RdW = AW'($urandom_range(0, 7)); hif.RegWriteW = 1'($urandom_range(0, 1));
            hif.LongIssueE = ($urandom_range(0, 2) == 0);
            hif.PCSrcE = !hif.LongIssueE && ($urandom_range(0, 4) == 0);
            hif.LongBusy = ($urandom_range(0, 3) == 0);
            hif.LongDone = ($urandom_range(0, 2) == 0);
            hif.LongRd = AW'($urandom_range(0, 7));
            pushExp("random");
            #1;
            e = q.pop_front();
            checks++;
            if (obsVec !== e.vec || hif.Pending !== e.pend) begin
                failures++;
                $display("FAIL %s[%0d] got=%b/%h exp=%b/%h", e.tag, i, obsVec, hif.Pending, e.vec, e.pend);
            end
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_scoreboard();
        test_structural();
        test_branch();
        test_long_fwd();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
